mdio_apb_mc: RTL and testbench

APB3 slave that runs MDIO management frames on one of NBUS independent MDIO buses. The MDIO frame engine is built in, and the block supports both Clause 22 and Clause 45 frames. It sits between the CPU APB fabric and the PHY management pins, replacing the fixed five-bus, Clause-22-only bridge. Adds error reporting (pslverr) and a configurable preamble length.

---
 rtl/mdio_apb_mc_if.sv | 22 ++
 rtl/mdio_apb_mc.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mdio_apb_mc.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_apb_mc_if.sv
// APB3 access port of the MDIO management bridge.
// The CPU side is the master and mdio_apb_mc is the slave.
interface mdio_apb_mc_if;
  logic [15:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/mdio_apb_mc.sv
// APB3 slave that runs one Clause 22 or Clause 45 MDIO frame per access.
// The frame goes out on one of NBUS buses, and the result returns with a one-cycle pready pulse.
module mdio_apb_mc #(
  parameter int NBUS    = 5,
  parameter int DIV     = 1000,
  parameter int PRE_LEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  mdio_apb_mc_if.slave    apb,
  output logic            mdc,
  output logic [NBUS-1:0] mdo,
  output logic [NBUS-1:0] mdt,
  input  logic [NBUS-1:0] mdi
);

  localparam int DW = $clog2(2 * DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PRE, S_HDR, S_TA, S_DATA, S_DONE, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic            wr_q, wr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [31:0]     tx_q, tx_d;
  logic [15:0]     rx_q, rx_d;
  logic [DW-1:0]   div_q, div_d;
  logic [5:0]      bit_q, bit_d;
  logic            err_q, err_d;
  logic            ta_err_q, ta_err_d;
  logic            mdc_q, mdc_d;
  logic [NBUS-1:0] mdo_q, mdo_d;
  logic [NBUS-1:0] mdt_q, mdt_d;
  logic [15:0]     prdata_q, prdata_d;
  logic            pready_q, pready_d;
  logic            pslverr_q, pslverr_d;

  logic [3:0]      sel_s;
  logic            bit_end_s;
  logic            rise_s;
  logic            chk_err_s;
  logic            mdi_sel_s;
  logic [1:0]      st_s;
  logic [1:0]      op_s;
  logic            drive_s;
  logic            bit_s;

  assign sel_s     = addr_q[15:12];
  assign bit_end_s = (div_q == DW'(2 * DIV - 1));
  assign rise_s    = (div_q == DW'(DIV));
  assign chk_err_s = ({1'b0, addr_q[15:12]} >= 5'(NBUS)) ||
                     (addr_q[6] && !addr_q[0] && !wr_q);

  // State and datapath registers; reset drops any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= 16'h0000;
      wr_q      <= 1'b0;
      wdata_q   <= 16'h0000;
      tx_q      <= 32'h0000_0000;
      rx_q      <= 16'h0000;
      div_q     <= '0;
      bit_q     <= 6'd0;
      err_q     <= 1'b0;
      ta_err_q  <= 1'b0;
      mdc_q     <= 1'b0;
      mdo_q     <= '0;
      mdt_q     <= '0;
      prdata_q  <= 16'h0000;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      err_q     <= err_d;
      ta_err_q  <= ta_err_d;
      mdc_q     <= mdc_d;
      mdo_q     <= mdo_d;
      mdt_q     <= mdt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Next-state logic: sequencing of frame fields, bit timing and mdi capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    div_d     = div_q;
    bit_d     = bit_q;
    err_d     = err_q;
    ta_err_d  = ta_err_q;
    mdi_sel_s = 1'b0;
    st_s      = 2'b01;
    op_s      = 2'b00;

    for (int i = 0; i < NBUS; i++) begin
      mdi_sel_s = mdi_sel_s | (mdi[i] & (sel_s == 4'(i)));
    end

    // C45 frames use ST=00, and paddr[0] selects an address or a data opcode.
    if (addr_q[6]) begin
      st_s = 2'b00;
      op_s = !addr_q[0] ? 2'b00 : (wr_q ? 2'b01 : 2'b11);
    end else begin
      st_s = 2'b01;
      op_s = wr_q ? 2'b01 : 2'b10;
    end

    if (state_q inside {S_PRE, S_HDR, S_TA, S_DATA, S_DONE}) begin
      div_d = bit_end_s ? '0 : div_q + DW'(1);
    end else begin
      div_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (apb.psel && apb.penable) begin
          state_d = S_CHECK;
          addr_d  = apb.paddr;
          wr_d    = apb.pwrite;
          wdata_d = apb.pwdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        bit_d    = 6'd0;
        rx_d     = 16'h0000;
        ta_err_d = 1'b0;
        tx_d     = {st_s, op_s, addr_q[11:7], addr_q[5:1], 2'b10,
                    wr_q ? wdata_q : 16'h0000};
        if (chk_err_s) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          err_d   = 1'b0;
          state_d = (PRE_LEN == 0) ? S_HDR : S_PRE;
        end
      end
      S_PRE: begin
        if (bit_end_s) begin
          if (bit_q == 6'(PRE_LEN - 1)) begin
            state_d = S_HDR;
            bit_d   = 6'd0;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end else begin
          bit_d = bit_q;
        end
      end
      S_HDR: begin
        if (bit_end_s) begin
          tx_d = {tx_q[30:0], 1'b0};
          if (bit_q == 6'd13) begin
            state_d = S_TA;
            bit_d   = 6'd0;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end else begin
          bit_d = bit_q;
        end
      end
      S_TA: begin
        // A PHY that answers pulls the second TA bit low.
        if (rise_s && (bit_q == 6'd1)) begin
          ta_err_d = !wr_q && mdi_sel_s;
        end else begin
          ta_err_d = ta_err_q;
        end
        if (bit_end_s) begin
          tx_d = {tx_q[30:0], 1'b0};
          if (bit_q == 6'd1) begin
            state_d = S_DATA;
            bit_d   = 6'd0;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end else begin
          bit_d = bit_q;
        end
      end
      S_DATA: begin
        if (rise_s && !wr_q) begin
          rx_d = {rx_q[14:0], mdi_sel_s};
        end else begin
          rx_d = rx_q;
        end
        if (bit_end_s) begin
          tx_d = {tx_q[30:0], 1'b0};
          if (bit_q == 6'd15) begin
            state_d = S_DONE;
            bit_d   = 6'd0;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end else begin
          bit_d = bit_q;
        end
      end
      S_DONE: begin
        if (bit_end_s) begin
          state_d = S_RESP;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from next-state values so the registered pins line up with the state register.
  always_comb begin
    mdc_d     = 1'b0;
    mdo_d     = '0;
    mdt_d     = '0;
    prdata_d  = 16'h0000;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    drive_s   = (state_d inside {S_PRE, S_HDR}) ||
                ((state_d inside {S_TA, S_DATA}) && wr_q);
    bit_s     = (state_d == S_PRE) ? 1'b1 : tx_d[31];

    if (state_d inside {S_PRE, S_HDR, S_TA, S_DATA}) begin
      mdc_d = (div_d >= DW'(DIV));
    end else begin
      mdc_d = 1'b0;
    end

    for (int i = 0; i < NBUS; i++) begin
      mdt_d[i] = drive_s && (sel_s == 4'(i));
      mdo_d[i] = drive_s && bit_s && (sel_s == 4'(i));
    end

    if (state_d == S_RESP) begin
      pready_d  = 1'b1;
      pslverr_d = err_d || ta_err_d;
      prdata_d  = (err_d || wr_q) ? 16'h0000 : rx_d;
    end else begin
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = 16'h0000;
    end
  end

  assign mdc         = mdc_q;
  assign mdo         = mdo_q;
  assign mdt         = mdt_q;
  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;

endmodule

// File: tb/tb_mdio_apb_mc.sv
// Directed bench for mdio_apb_mc: C22/C45 frames, a PHY read model, error responses,
// a reset in the middle of a frame, and a second instance built with PRE_LEN=0.
module tb_mdio_apb_mc;
  localparam int NBUS = 5;
  localparam int DIV  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdio_apb_mc_if apb1 ();
  mdio_apb_mc_if apb0 ();

  logic [15:0] paddr_r, pwdata_r;
  logic        pwrite_r, psel_r, penable_r, tgt;

  assign apb1.paddr   = paddr_r;
  assign apb1.pwrite  = pwrite_r;
  assign apb1.pwdata  = pwdata_r;
  assign apb1.psel    = psel_r & ~tgt;
  assign apb1.penable = penable_r & ~tgt;
  assign apb0.paddr   = paddr_r;
  assign apb0.pwrite  = pwrite_r;
  assign apb0.pwdata  = pwdata_r;
  assign apb0.psel    = psel_r & tgt;
  assign apb0.penable = penable_r & tgt;

  logic        pready_s, pslverr_s;
  logic [15:0] prdata_s;
  assign pready_s  = tgt ? apb0.pready  : apb1.pready;
  assign pslverr_s = tgt ? apb0.pslverr : apb1.pslverr;
  assign prdata_s  = tgt ? apb0.prdata  : apb1.prdata;

  logic            mdc1, mdc0;
  logic [NBUS-1:0] mdo1, mdt1, mdi1, mdo0, mdt0;

  mdio_apb_mc #(.NBUS(NBUS), .DIV(DIV), .PRE_LEN(32)) u_dut (
    .clk(clk), .rst(rst), .apb(apb1.slave),
    .mdc(mdc1), .mdo(mdo1), .mdt(mdt1), .mdi(mdi1)
  );

  mdio_apb_mc #(.NBUS(NBUS), .DIV(DIV), .PRE_LEN(0)) u_dut0 (
    .clk(clk), .rst(rst), .apb(apb0.slave),
    .mdc(mdc0), .mdo(mdo0), .mdt(mdt0), .mdi(5'b11111)
  );

  // Pin history of the main instance, one entry per mdc rising edge.
  int              rise_cnt = 0;
  int              fall_cnt = 0;
  logic [NBUS-1:0] hist_mdo [1024];
  logic [NBUS-1:0] hist_mdt [1024];
  always @(posedge mdc1) begin
    hist_mdo[rise_cnt % 1024] <= mdo1;
    hist_mdt[rise_cnt % 1024] <= mdt1;
    rise_cnt <= rise_cnt + 1;
  end
  always @(negedge mdc1) fall_cnt <= fall_cnt + 1;

  int          rise0 = 0;
  logic [31:0] cap0  = 32'h0;
  always @(posedge mdc0) begin
    if (rise0 < 32) cap0[31 - rise0] <= mdo0[0];
    rise0 <= rise0 + 1;
  end

  // PHY model: presents bit k after the k-th mdc fall; TA = z(pulled up),0 then data.
  logic        phy_on;
  int          phy_bus;
  logic [15:0] phy_data;
  int          base_r, base_f;

  function automatic logic phy_bit(input int k, input logic [15:0] d);
    if (k == 47) return 1'b0;
    if (k >= 48 && k <= 63) return d[63 - k];
    return 1'b1;
  endfunction

  always_comb begin
    mdi1 = '1;
    if (phy_on) mdi1[phy_bus] = phy_bit(fall_cnt - base_f, phy_data);
  end

  function automatic logic [63:0] frame(input int b, input int base, input bit use_mdt);
    logic [63:0] v;
    v = 64'h0;
    for (int k = 0; k < 64; k++)
      v[63 - k] = use_mdt ? hist_mdt[(base + k) % 1024][b] : hist_mdo[(base + k) % 1024][b];
    return v;
  endfunction

  function automatic logic other_act(input int b, input int base);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 64; k++)
      for (int i = 0; i < NBUS; i++)
        if (i != b) acc = acc | hist_mdo[(base + k) % 1024][i] | hist_mdt[(base + k) % 1024][i];
    return acc;
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic t, input logic [15:0] a, input logic w, input logic [15:0] d,
                     output logic [15:0] rd, output logic e, output int cyc);
    @(negedge clk);
    tgt = t; paddr_r = a; pwrite_r = w; pwdata_r = d;
    psel_r = 1'b1; penable_r = 1'b0;
    base_r = rise_cnt; base_f = fall_cnt;
    @(negedge clk);
    penable_r = 1'b1;
    cyc = 0; rd = 16'h0; e = 1'b0;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (pready_s) begin
        rd = prdata_s; e = pslverr_s;
        break;
      end
    end
    @(negedge clk);
    psel_r = 1'b0; penable_r = 1'b0;
  endtask

  logic [15:0] rd;
  logic        e;
  int          cyc;
  int          guard;

  initial begin
    rst = 1'b1; tgt = 1'b0; paddr_r = 16'h0; pwdata_r = 16'h0; pwrite_r = 1'b0;
    psel_r = 1'b0; penable_r = 1'b0; phy_on = 1'b0; phy_bus = 0; phy_data = 16'h0;
    base_r = 0; base_f = 0;
    repeat (3) @(negedge clk);
    chk("rst_mdc", 64'(mdc1), 64'd0);
    chk("rst_mdo", 64'(mdo1), 64'd0);
    chk("rst_mdt", 64'(mdt1), 64'd0);
    chk("rst_prdata", 64'(apb1.prdata), 64'd0);
    chk("rst_pready", 64'(apb1.pready), 64'd0);
    chk("rst_pslverr", 64'(apb1.pslverr), 64'd0);
    rst = 1'b0;

    // C22 write, bus1 phy1 reg2
    apb(1'b0, 16'h1084, 1'b1, 16'hA5A5, rd, e, cyc);
    chk("c22w_lat", 64'(cyc >= 261 && cyc <= 263), 64'd1);
    chk("c22w_err", 64'(e), 64'd0);
    chk("c22w_rd", 64'(rd), 64'd0);
    chk("c22w_mdo", frame(1, base_r, 1'b0), {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd2, 2'b10, 16'hA5A5});
    chk("c22w_mdt", frame(1, base_r, 1'b1), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("c22w_other", 64'(other_act(1, base_r)), 64'd0);
    chk("c22w_bits", 64'(rise_cnt - base_r), 64'd64);

    // C22 read, bus3 phy5 reg1 with responding PHY
    phy_on = 1'b1; phy_bus = 3; phy_data = 16'h1234;
    apb(1'b0, 16'h3282, 1'b0, 16'h0000, rd, e, cyc);
    chk("c22r_rd", 64'(rd), 64'h1234);
    chk("c22r_err", 64'(e), 64'd0);
    chk("c22r_mdo", frame(3, base_r, 1'b0), {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd5, 5'd1, 18'h0});
    chk("c22r_mdt", frame(3, base_r, 1'b1), 64'hFFFF_FFFF_FFFC_0000);
    chk("c22r_other", 64'(other_act(3, base_r)), 64'd0);

    // C22 read with no PHY
    phy_on = 1'b0;
    apb(1'b0, 16'h3282, 1'b0, 16'h0000, rd, e, cyc);
    chk("nophy_rd", 64'(rd), 64'hFFFF);
    chk("nophy_err", 64'(e), 64'd1);

    // C45 address then C45 read, bus2 port3 devad1
    apb(1'b0, 16'h21C2, 1'b1, 16'h0010, rd, e, cyc);
    chk("c45a_err", 64'(e), 64'd0);
    chk("c45a_mdo", frame(2, base_r, 1'b0), {32'hFFFF_FFFF, 2'b00, 2'b00, 5'd3, 5'd1, 2'b10, 16'h0010});
    phy_on = 1'b1; phy_bus = 2; phy_data = 16'hBEEF;
    apb(1'b0, 16'h21C3, 1'b0, 16'h0000, rd, e, cyc);
    chk("c45r_mdo", frame(2, base_r, 1'b0), {32'hFFFF_FFFF, 2'b00, 2'b11, 5'd3, 5'd1, 18'h0});
    chk("c45r_rd", 64'(rd), 64'hBEEF);
    chk("c45r_err", 64'(e), 64'd0);
    phy_on = 1'b0;

    // Error responses
    apb(1'b0, 16'h7000, 1'b1, 16'h1111, rd, e, cyc);
    chk("badbus_err", 64'(e), 64'd1);
    chk("badbus_lat", 64'(cyc), 64'd2);
    chk("badbus_rd", 64'(rd), 64'd0);
    chk("badbus_mdc", 64'(rise_cnt - base_r), 64'd0);
    apb(1'b0, 16'h21C2, 1'b0, 16'h0000, rd, e, cyc);
    chk("c45ar_err", 64'(e), 64'd1);
    chk("c45ar_lat", 64'(cyc), 64'd2);
    chk("c45ar_mdc", 64'(rise_cnt - base_r), 64'd0);

    // Reset in the DATA phase of a write, then a clean access
    @(negedge clk);
    tgt = 1'b0; paddr_r = 16'h1084; pwrite_r = 1'b1; pwdata_r = 16'hFFFF;
    psel_r = 1'b1; penable_r = 1'b0; base_r = rise_cnt;
    @(negedge clk);
    penable_r = 1'b1;
    guard = 0;
    while ((rise_cnt - base_r) < 52 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_reached", 64'((rise_cnt - base_r) >= 52), 64'd1);
    chk("mid_mdt_on", 64'(mdt1), 64'h2);
    rst = 1'b1; psel_r = 1'b0; penable_r = 1'b0;
    #1;
    chk("mid_rst_mdc", 64'(mdc1), 64'd0);
    chk("mid_rst_mdo", 64'(mdo1), 64'd0);
    chk("mid_rst_mdt", 64'(mdt1), 64'd0);
    chk("mid_rst_pready", 64'(apb1.pready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apb(1'b0, 16'h1084, 1'b1, 16'hA5A5, rd, e, cyc);
    chk("post_lat", 64'(cyc >= 261 && cyc <= 263), 64'd1);
    chk("post_err", 64'(e), 64'd0);
    chk("post_mdo", frame(1, base_r, 1'b0), {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd2, 2'b10, 16'hA5A5});

    // PRE_LEN=0 instance: frame starts with ST
    apb(1'b1, 16'h0084, 1'b1, 16'h5A5A, rd, e, cyc);
    chk("nopre_mdo", 64'(cap0), 64'({2'b01, 2'b01, 5'd1, 5'd2, 2'b10, 16'h5A5A}));
    chk("nopre_bits", 64'(rise0), 64'd32);
    chk("nopre_err", 64'(e), 64'd0);
    chk("nopre_lat", 64'(cyc >= 133 && cyc <= 135), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
